// File: rtl/dac_spi_tx.sv
// Serial frame transmitter for a 16-bit SPI DAC: {CTRL_BYTE, sample}, MSB first, sync active low.
// Define DAC_SPI_TX_SKID_EN to add a one-entry holding buffer so the next sample can queue mid-frame.
module dac_spi_tx #(
  parameter int          CLK_DIV   = 1,
  parameter logic [7:0]  CTRL_BYTE = 8'h40,
  parameter int          GAP_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       sclk,
  output logic       sync,
  output logic       din,
  output logic       busy,
  output logic       frame_done
);

  // state | meaning
  // IDLE  | no frame; ready for a sample
  // SHIFT | sync low, 16 bits clocked out on sclk
  // GAP   | sync high between frames; first cycle carries frame_done

  localparam int DIV_EFF = (CLK_DIV < 1) ? 1 : ((CLK_DIV > 255) ? 255 : CLK_DIV);
  localparam int GAP_EFF = (GAP_CYC < 1) ? 1 : ((GAP_CYC > 15) ? 15 : GAP_CYC);
`ifdef DAC_SPI_TX_SKID_EN
  localparam int GAP_LEN = GAP_EFF;
`else
  // The IDLE cycle that precedes a handshake is itself a sync-high cycle,
  // so GAP is one shorter to keep the minimum spacing at GAP_CYC.
  localparam int GAP_LEN = (GAP_EFF > 1) ? GAP_EFF - 1 : 1;
`endif
  localparam logic [7:0] DIV_LAST = 8'(DIV_EFF - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_LEN - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t      state_q, state_d;
  logic [14:0] shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        sclk_q, sclk_d;
  logic        sync_q, sync_d;
  logic        din_q, din_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        sample_ready_q, sample_ready_d;
  logic        start;
  logic [7:0]  start_data;
`ifdef DAC_SPI_TX_SKID_EN
  logic [7:0]  buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
`endif

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bit_cnt_d      = bit_cnt_q;
    div_cnt_d      = div_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    sclk_d         = sclk_q;
    sync_d         = sync_q;
    din_d          = din_q;
    frame_done_d   = 1'b0;
    start          = 1'b0;
    start_data     = sample;
`ifdef DAC_SPI_TX_SKID_EN
    buf_d          = buf_q;
    buf_full_d     = buf_full_q;
`endif

    case (state_q)
      IDLE: begin
        if (sample_valid && sample_ready_q) start = 1'b1;
      end
      SHIFT: begin
        if (div_cnt_q != 8'd0) begin
          div_cnt_d = div_cnt_q - 8'd1;
        end else begin
          div_cnt_d = DIV_LAST;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_cnt_q == 4'd0) begin
            state_d      = GAP;
            sync_d       = 1'b1;
            sclk_d       = 1'b0;
            din_d        = 1'b0;
            frame_done_d = 1'b1;
            gap_cnt_d    = GAP_LAST;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
            sclk_d    = 1'b0;
            din_d     = shreg_q[14];
            shreg_d   = {shreg_q[13:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (gap_cnt_q != 4'd0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end else begin
`ifdef DAC_SPI_TX_SKID_EN
          if (buf_full_q) begin
            start      = 1'b1;
            start_data = buf_q;
            buf_full_d = 1'b0;
          end else if (sample_valid && sample_ready_q) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef DAC_SPI_TX_SKID_EN
    if (state_q != IDLE && !start && sample_valid && sample_ready_q) begin
      buf_d      = sample;
      buf_full_d = 1'b1;
    end
`endif

    if (start) begin
      state_d   = SHIFT;
      sync_d    = 1'b0;
      sclk_d    = 1'b0;
      din_d     = CTRL_BYTE[7];
      shreg_d   = {CTRL_BYTE[6:0], start_data};
      bit_cnt_d = 4'd15;
      div_cnt_d = DIV_LAST;
    end

    busy_d = (state_d != IDLE);
`ifdef DAC_SPI_TX_SKID_EN
    sample_ready_d = !buf_full_d;
`else
    sample_ready_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      div_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      sclk_q         <= 1'b0;
      sync_q         <= 1'b1;
      din_q          <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      sample_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      div_cnt_q      <= div_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      sclk_q         <= sclk_d;
      sync_q         <= sync_d;
      din_q          <= din_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      sample_ready_q <= sample_ready_d;
    end
  end

`ifdef DAC_SPI_TX_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end
`endif

  assign sample_ready = sample_ready_q;
  assign sclk         = sclk_q;
  assign sync         = sync_q;
  assign din          = din_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule
